// File: rtl/bus_pkg.sv
// bus_pkg: FSM states, slave-ID width and master index shared by the bus arbiter.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, ACTIVE, RELEASE} state_e;
  localparam int SLV_ID_BITS = 2;
  typedef enum logic {M1, M2} mst_e;
endpackage

// File: rtl/counter.sv
// counter: up-counter with synchronous clear, used as the arbiter's grant timeout.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic             incr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (rst) count <= '0;
    else if (incr) count <= count + WIDTH'(1);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master, N-slave bus arbiter with serial slave-ID decode and grant timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build is fixed priority M1 > M2.
module bus_arbiter import bus_pkg::*; #(
  parameter int N_SLAVES    = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                M1_BREQ,
  input  logic                M2_BREQ,
  output logic                M1_BGRANT,
  output logic                M2_BGRANT,
  input  logic                M1_BUS_OUT,
  input  logic                M2_BUS_OUT,
  input  logic                M1_MVALID,
  input  logic                M2_MVALID,
  input  logic                M1_RW,
  input  logic                M2_RW,
  output logic                B_BUS_OUT,
  output logic                B_RW,
  output logic [N_SLAVES-1:0] AD_SEL,
  input  logic [N_SLAVES-1:0] S_ACK,
  input  logic [N_SLAVES-1:0] S_SBSY,
  input  logic [N_SLAVES-1:0] S_READY,
  input  logic [N_SLAVES-1:0] S_BUS_IN,
  output logic                B_ACK,
  output logic                B_SBSY,
  output logic                B_READY,
  output logic                B_BUS_IN,
  output logic                ARB_BUSY,
  output logic                ARB_ERR
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam int NB = $clog2(SLV_ID_BITS + 1);
  state_e                 r_state, w_next;
  mst_e                   r_owner, w_owner, w_win;
  logic [SLV_ID_BITS-1:0] r_id, w_id;
  logic [NB-1:0]          r_nbits, w_nbits;
  logic                   r_err, w_err;
  logic [CW-1:0]          w_count;
  logic                   w_req_own, w_vld_own, w_bit_own, w_rw_own, w_held, w_act;

  assign w_req_own = r_owner == M2 ? M2_BREQ   : M1_BREQ;
  assign w_vld_own = r_owner == M2 ? M2_MVALID : M1_MVALID;
  assign w_bit_own = r_owner == M2 ? M2_BUS_OUT : M1_BUS_OUT;
  assign w_rw_own  = r_owner == M2 ? M2_RW     : M1_RW;

`ifdef ARB_ROUND_ROBIN_EN
  mst_e r_last;
  assign w_win = (M1_BREQ && M2_BREQ) ? (r_last == M1 ? M2 : M1) : (M1_BREQ ? M1 : M2);
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) r_last <= M2;
    else if (r_state == IDLE && (M1_BREQ || M2_BREQ)) r_last <= w_win;
`else
  assign w_win = M1_BREQ ? M1 : M2;
`endif

  counter #(.WIDTH(CW)) u_tmo (
    .clk   (CLK),
    .rst_n (RSTN),
    .rst   (!w_act),
    .incr  (w_act),
    .count (w_count)
  );

  always_comb begin
    w_next  = r_state;
    w_owner = r_owner;
    w_id    = r_id;
    w_nbits = r_nbits;
    w_err   = 1'b0;
    case (r_state)
      IDLE:
        if (M1_BREQ || M2_BREQ) begin
          w_next  = ADDR;
          w_owner = w_win;
          w_id    = '0;
          w_nbits = '0;
        end
      // Once all ID bits are in, one decode cycle picks ACTIVE or an error release.
      ADDR:
        if (r_nbits == NB'(SLV_ID_BITS)) begin
          w_next = int'(r_id) < N_SLAVES ? ACTIVE : RELEASE;
          w_err  = !(int'(r_id) < N_SLAVES);
        end else if (w_vld_own) begin
          w_id    = {w_bit_own, r_id[SLV_ID_BITS-1:1]};
          w_nbits = r_nbits + NB'(1);
        end
      // A dropped request takes precedence over a simultaneous timeout.
      ACTIVE:
        if (!w_req_own) w_next = RELEASE;
        else if (w_count == CW'(TIMEOUT_CYC - 1)) begin
          w_next = RELEASE;
          w_err  = 1'b1;
        end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      r_state <= IDLE;
      r_owner <= M1;
      r_id    <= '0;
      r_nbits <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_owner <= w_owner;
      r_id    <= w_id;
      r_nbits <= w_nbits;
      r_err   <= w_err;
    end

  assign w_held    = r_state == ADDR || r_state == ACTIVE;
  assign w_act     = r_state == ACTIVE;
  assign M1_BGRANT = w_held && r_owner == M1;
  assign M2_BGRANT = w_held && r_owner == M2;
  assign B_BUS_OUT = w_held && w_bit_own;
  assign B_RW      = w_held && w_rw_own;
  assign AD_SEL    = w_act ? N_SLAVES'(1) << r_id : '0;
  assign B_ACK     = |(S_ACK & AD_SEL);
  assign B_SBSY    = |(S_SBSY & AD_SEL);
  assign B_READY   = |(S_READY & AD_SEL);
  assign B_BUS_IN  = |(S_BUS_IN & AD_SEL);
  assign ARB_BUSY  = r_state != IDLE;
  assign ARB_ERR   = r_err;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: randomized transaction-level bench for bus_arbiter with an in-bench timing model.
module tb_bus_arbiter;
  localparam int N = 3;
  localparam int TMO = 255;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  logic M1_BREQ = 0, M2_BREQ = 0, M1_BGRANT, M2_BGRANT;
  logic M1_BUS_OUT = 0, M2_BUS_OUT = 0, M1_MVALID = 0, M2_MVALID = 0, M1_RW = 0, M2_RW = 0;
  logic B_BUS_OUT, B_RW, B_ACK, B_SBSY, B_READY, B_BUS_IN, ARB_BUSY, ARB_ERR;
  logic [N-1:0] AD_SEL;
  logic [N-1:0] S_ACK = '0, S_SBSY = '0, S_READY = '0, S_BUS_IN = '0;
  int n_tests = 0, n_fail = 0;
  int last_m = 2;

  always #5 clk = ~clk;

  bus_arbiter #(.N_SLAVES(N), .TIMEOUT_CYC(TMO)) dut (
    .CLK(clk), .RSTN(rstn),
    .M1_BREQ(M1_BREQ), .M2_BREQ(M2_BREQ), .M1_BGRANT(M1_BGRANT), .M2_BGRANT(M2_BGRANT),
    .M1_BUS_OUT(M1_BUS_OUT), .M2_BUS_OUT(M2_BUS_OUT), .M1_MVALID(M1_MVALID), .M2_MVALID(M2_MVALID),
    .M1_RW(M1_RW), .M2_RW(M2_RW), .B_BUS_OUT(B_BUS_OUT), .B_RW(B_RW), .AD_SEL(AD_SEL),
    .S_ACK(S_ACK), .S_SBSY(S_SBSY), .S_READY(S_READY), .S_BUS_IN(S_BUS_IN),
    .B_ACK(B_ACK), .B_SBSY(B_SBSY), .B_READY(B_READY), .B_BUS_IN(B_BUS_IN),
    .ARB_BUSY(ARB_BUSY), .ARB_ERR(ARB_ERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_rand();
    {M1_BUS_OUT, M2_BUS_OUT, M1_RW, M2_RW, M1_MVALID, M2_MVALID} = 6'($urandom);
    S_ACK = N'($urandom);
    S_SBSY = N'($urandom);
    S_READY = N'($urandom);
    S_BUS_IN = N'($urandom);
  endtask

  task automatic set_req(input int own, input bit v);
    if (own == 1) begin M1_BREQ = v; M2_BREQ = 1'($urandom); end
    else begin M2_BREQ = v; M1_BREQ = 1'($urandom); end
  endtask

  task automatic set_mv(input int own, input bit v, input bit b);
    if (own == 1) begin M1_MVALID = v; M1_BUS_OUT = b; end
    else begin M2_MVALID = v; M2_BUS_OUT = b; end
  endtask

  function automatic bit sl(input logic [N-1:0] v, input int id, input bit act);
    return act && ((int'(v) >> id) & 1) != 0;
  endfunction

  // Checks every output for one cycle, then advances to just after the next edge.
  task automatic cyc(input bit held, input bit act, input int own, input int id, input bit err, input bit busy);
    #2;
    check("m1_bgrant", 32'(M1_BGRANT), 32'(held && own == 1));
    check("m2_bgrant", 32'(M2_BGRANT), 32'(held && own == 2));
    check("b_bus_out", 32'(B_BUS_OUT), 32'(held && (own == 1 ? M1_BUS_OUT : M2_BUS_OUT)));
    check("b_rw", 32'(B_RW), 32'(held && (own == 1 ? M1_RW : M2_RW)));
    check("ad_sel", 32'(AD_SEL), act ? 32'(1) << id : 32'(0));
    check("b_ack", 32'(B_ACK), 32'(sl(S_ACK, id, act)));
    check("b_sbsy", 32'(B_SBSY), 32'(sl(S_SBSY, id, act)));
    check("b_ready", 32'(B_READY), 32'(sl(S_READY, id, act)));
    check("b_bus_in", 32'(B_BUS_IN), 32'(sl(S_BUS_IN, id, act)));
    check("arb_err", 32'(ARB_ERR), 32'(err));
    check("arb_busy", 32'(ARB_BUSY), 32'(busy));
    @(posedge clk);
    #1;
  endtask

  task automatic rst_outs(input string tag);
    check({tag, "_gnt"}, 32'({M1_BGRANT, M2_BGRANT}), 32'(0));
    check({tag, "_adsel"}, 32'(AD_SEL), 32'(0));
    check({tag, "_route"}, 32'({B_ACK, B_SBSY, B_READY, B_BUS_IN, B_BUS_OUT, B_RW}), 32'(0));
    check({tag, "_flags"}, 32'({ARB_ERR, ARB_BUSY}), 32'(0));
  endtask

  // One full transfer: request, serial ID, hold BREQ for h ACTIVE cycles, release.
  task automatic txn(input bit r1, input bit r2, input int id, input int h, input int abort);
    int own, n_act;
    bit err;
    own = (r1 && r2) ? (RR ? (last_m == 2 ? 1 : 2) : 1) : (r1 ? 1 : 2);
    if (RR) last_m = own;
    drive_rand();
    M1_BREQ = r1; M2_BREQ = r2;
    cyc(0, 0, own, id, 0, 0);
    for (int b = 0; b < 2; b++) begin
      int st = $urandom_range(0, 2);
      for (int s = 0; s < st; s++) begin
        drive_rand(); set_req(own, 1); set_mv(own, 0, 1'($urandom));
        cyc(1, 0, own, id, 0, 1);
      end
      drive_rand(); set_req(own, 1); set_mv(own, 1, 1'((id >> b) & 1));
      cyc(1, 0, own, id, 0, 1);
    end
    drive_rand(); set_req(own, 1);
    cyc(1, 0, own, id, 0, 1);
    if (id >= N) begin
      drive_rand(); M1_BREQ = 0; M2_BREQ = 0;
      cyc(0, 0, own, id, 1, 1);
      cyc(0, 0, own, id, 0, 0);
      return;
    end
    n_act = (h + 1 < TMO) ? h + 1 : TMO;
    err = h >= TMO;
    for (int k = 1; k <= n_act; k++) begin
      drive_rand(); set_req(own, k <= h);
      if (k == abort) begin
        {S_ACK, S_SBSY, S_READY, S_BUS_IN} = '1;
        {M1_BUS_OUT, M2_BUS_OUT, M1_RW, M2_RW} = '1;
        #1 rstn = 1'b0;
        #1 rst_outs("rst_async");
        @(posedge clk); #1;
        rst_outs("rst_held");
        M1_BREQ = 0; M2_BREQ = 0; rstn = 1'b1; last_m = 2;
        @(posedge clk); #1;
        return;
      end
      cyc(1, 1, own, id, 0, 1);
    end
    drive_rand(); M1_BREQ = 0; M2_BREQ = 0;
    cyc(0, 0, own, id, err, 1);
    cyc(0, 0, own, id, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    M1_BREQ = 1'b1; S_ACK = '1;
    #3 rst_outs("reset");
    @(posedge clk); #1;
    rst_outs("reset_edge");
    #5 M1_BREQ = 1'b0; rstn = 1'b1;
    @(posedge clk); #1;
    txn(1, 0, 1, 5, 0);
    txn(1, 0, 0, 3, 0);
    for (int t = 0; t < 3; t++) txn(1, 1, $urandom_range(0, N - 1), 3, 0);
    txn(0, 1, 3, 2, 0);
    txn(1, 0, 2, 300, 0);
    txn(0, 1, 0, 254, 0);
    txn(1, 0, 1, 10, 3);
    txn(0, 1, 2, 2, 0);
    for (int t = 0; t < 40; t++) begin
      int r = $urandom_range(1, 3);
      txn(r[0], r[1], $urandom_range(0, 3), $urandom_range(1, 12), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
